am_tx_sched: RTL

Alignment-marker scheduler for the 40GBASE-R transmit PCS (4 lanes, 66-bit blocks). It decides in which cycle the alignment-marker inserter replaces the block on every lane with an alignment marker. The period is one marker per AM_PERIOD blocks per lane. The scheduler also stalls the upstream encoder/scrambler for that slot and honours gearbox pauses from the PMA side. It sits between the 64b/66b encoder stage and `alignement_marker_tx`, and drives that block's marker-slot and BIP-restart controls.

---
 rtl/am_tx_sched.sv | 99 +++++++++
 1 files changed

// File: rtl/am_tx_sched.sv
// Alignment-marker scheduler for the 4-lane 40GBASE-R transmit PCS.
// Picks the cycle in which every lane carries an alignment marker, stalls
// the upstream encoder for that slot and freezes the period on gearbox pauses.
module am_tx_sched #(
    parameter int LANE_N    = 4,
    parameter int AM_PERIOD = 16384,
    parameter int CNT_W     = $clog2(AM_PERIOD)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en_i,
    input  logic             gb_pause_i,
    output logic             ready_o,
    output logic             marker_v_o,
    output logic             bip_clr_o,
    output logic [CNT_W-1:0] slot_cnt_o,
    output logic [15:0]      marker_cnt_o,
    output logic             active_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 1);

    // Elaborates only for an unusable configuration (no lanes or a period
    // too short to leave room for data between markers).
    if (LANE_N < 1 || AM_PERIOD < 4) begin : g_bad_param_unsupported
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      marker_cnt_q, marker_cnt_d;

    logic run;
    logic slot0;
    logic act;
    logic marker_v;

    // Output decode: purely from registered state and the pause input, so en_i
    // never reaches an output in the same cycle; reset masks the strobes.
    always_comb begin
        run      = (state_q == S_RUN);
        slot0    = (cnt_q == '0);
        act      = !gb_pause_i;
        marker_v = nreset & run & slot0 & act;
        ready_o  = nreset & act & !(run & slot0);
    end

    assign marker_v_o   = marker_v;
    assign bip_clr_o    = marker_v;
    assign slot_cnt_o   = cnt_q;
    assign marker_cnt_o = marker_cnt_q;
    assign active_o     = run;

    // Next-state: period counter advances only on active RUN cycles; leaving
    // or entering RUN always restarts the period at the marker slot.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        marker_cnt_d = marker_cnt_q + {15'd0, marker_v};
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (act) begin
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            marker_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            marker_cnt_q <= marker_cnt_d;
        end
    end

endmodule
